// File: rtl/driver_display_scan.sv
// Multiplexed segment-display scanner with double-buffered patterns and per-digit enables.
// Optional DRIVER_DISPLAY_DIM_EN adds a 4-bit brightness input that shortens each digit's ON time.
`timescale 1ns / 1ps

module driver_display_scan #(
   parameter int unsigned      NUM_DIGITS    = 4,
   parameter int unsigned      SEG_W         = 8,
   parameter int unsigned      PRESCALE      = 1000,
   parameter int unsigned      DEAD_CYCLES   = 2,
   parameter logic [SEG_W-1:0] BLANK_PATTERN = '1
) (
   input  logic                        display_clock,
   input  logic                        reset_n,
   input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]       digit_en,
   input  logic                        load,
`ifdef DRIVER_DISPLAY_DIM_EN
   input  logic [3:0]                  brightness,
`endif
   output logic [NUM_DIGITS-1:0]       digits,
   output logic [SEG_W-1:0]            segments,
   output logic                        frame_done
);

   localparam int unsigned CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
   localparam int unsigned PC_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam bit          NO_DEAD = (DEAD_CYCLES == 0);

   localparam logic [PC_W-1:0]  PS_LAST   = PC_W'(PRESCALE - 1);
   localparam logic [PC_W-1:0]  DEAD_LAST = PC_W'(NO_DEAD ? 0 : DEAD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {StActive, StDead} state_e;

   state_e                             state_q;
   logic [PC_W-1:0]                    pc_q;
   logic [IDX_W-1:0]                   idx_q;
   logic [NUM_DIGITS-1:0][SEG_W-1:0]   pend_pat_q;
   logic [NUM_DIGITS-1:0][SEG_W-1:0]   act_pat_q;
   logic [NUM_DIGITS-1:0]              pend_mask_q;
   logic [NUM_DIGITS-1:0]              act_mask_q;
   logic                               pend_q;

   logic                  advance;
   logic                  boundary;
   logic                  sel_on;
   logic [IDX_W-1:0]      idx_next;
   logic [NUM_DIGITS-1:0] digits_d;
   logic [SEG_W-1:0]      segments_d;

   always_comb begin
      advance  = ((state_q == StActive) && (pc_q == PS_LAST) && NO_DEAD) ||
                 ((state_q == StDead) && (pc_q == DEAD_LAST));
      boundary = advance && (idx_q == IDX_LAST);
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
   end

   always_comb begin
      sel_on = (state_q == StActive) && act_mask_q[idx_q];
`ifdef DRIVER_DISPLAY_DIM_EN
      // ON for the first (brightness+1)/16 of the slot
      sel_on = sel_on &&
               ((32'(pc_q) << 4) < ((32'(brightness) + 32'd1) * PRESCALE));
`endif
      digits_d   = '1;
      segments_d = BLANK_PATTERN;
      if (sel_on) begin
         digits_d[idx_q] = 1'b0;
         segments_d      = act_pat_q[idx_q];
      end
   end

   always_ff @(posedge display_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StActive;
         pc_q        <= '0;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         pend_pat_q  <= {NUM_DIGITS{BLANK_PATTERN}};
         act_pat_q   <= {NUM_DIGITS{BLANK_PATTERN}};
         pend_mask_q <= '0;
         act_mask_q  <= '0;
         digits      <= '1;
         segments    <= BLANK_PATTERN;
         frame_done  <= 1'b0;
      end else begin
         unique case (state_q)
            StActive: begin
               if (pc_q == PS_LAST) begin
                  pc_q <= '0;
                  if (NO_DEAD) begin
                     idx_q <= idx_next;
                  end else begin
                     state_q <= StDead;
                  end
               end else begin
                  pc_q <= pc_q + 1'b1;
               end
            end
            StDead: begin
               if (pc_q == DEAD_LAST) begin
                  pc_q    <= '0;
                  idx_q   <= idx_next;
                  state_q <= StActive;
               end else begin
                  pc_q <= pc_q + 1'b1;
               end
            end
         endcase

         // A load landing on the boundary bypasses the pending buffer
         if (boundary) begin
            if (load) begin
               act_pat_q  <= digits_in;
               act_mask_q <= digit_en;
            end else if (pend_q) begin
               act_pat_q  <= pend_pat_q;
               act_mask_q <= pend_mask_q;
            end
            pend_q <= 1'b0;
         end else if (load) begin
            pend_pat_q  <= digits_in;
            pend_mask_q <= digit_en;
            pend_q      <= 1'b1;
         end

         digits     <= digits_d;
         segments   <= segments_d;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_driver_display_scan.sv
// Randomized bench for driver_display_scan: two instances (DEAD_CYCLES=1 and 0) checked every
// cycle against a frame/slot arithmetic model, plus literal scan-sequence and period checks.
`timescale 1ns / 1ps

module tb_driver_display_scan;

   localparam int PS  = 4;
   localparam int P0  = 20;
   localparam int P1  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din = '0;
   logic [3:0]  den = '0;
   logic        load = 1'b0;
   logic [3:0]  dig0, dig1;
   logic [7:0]  seg0, seg1;
   logic        fd0, fd1;
`ifdef DRIVER_DISPLAY_DIM_EN
   logic [3:0]  brightness = 4'd15;
`endif

   always #5 clk = ~clk;

   driver_display_scan #(
      .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(PS), .DEAD_CYCLES(1), .BLANK_PATTERN(8'hFF)
   ) u_dut0 (
      .display_clock(clk),
      .reset_n      (rst_n),
      .digits_in    (din),
      .digit_en     (den),
      .load         (load),
`ifdef DRIVER_DISPLAY_DIM_EN
      .brightness   (brightness),
`endif
      .digits       (dig0),
      .segments     (seg0),
      .frame_done   (fd0)
   );

   driver_display_scan #(
      .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(PS), .DEAD_CYCLES(0), .BLANK_PATTERN(8'hFF)
   ) u_dut1 (
      .display_clock(clk),
      .reset_n      (rst_n),
      .digits_in    (din),
      .digit_en     (den),
      .load         (load),
`ifdef DRIVER_DISPLAY_DIM_EN
      .brightness   (brightness),
`endif
      .digits       (dig1),
      .segments     (seg1),
      .frame_done   (fd1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cnt = rising edges since reset release; outputs after edge cnt show state cnt-1.
   int          cnt;
   bit          has_load;
   logic [31:0] last_val;
   logic [3:0]  last_mask;
   int          last_idx;
   logic [31:0] act_pat [2];
   logic [3:0]  act_mask [2];
   logic [31:0] out_pat [2];
   logic [3:0]  out_mask [2];
   int          bnd_prev [2];

   function automatic int period(input int m);
      return (m == 0) ? P0 : P1;
   endfunction

   function automatic int dead(input int m);
      return (m == 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      cnt      = 0;
      has_load = 0;
      last_idx = 0;
      for (int m = 0; m < 2; m++) begin
         act_pat[m]  = 32'hFFFF_FFFF;
         act_mask[m] = 4'h0;
         out_pat[m]  = 32'hFFFF_FFFF;
         out_mask[m] = 4'h0;
         bnd_prev[m] = 0;
      end
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n) begin
         if (load) begin
            has_load  = 1;
            last_val  = din;
            last_mask = den;
            last_idx  = cnt;
         end
         cnt++;
         for (int m = 0; m < 2; m++) begin
            out_pat[m]  = act_pat[m];
            out_mask[m] = act_mask[m];
            if (cnt % period(m) == 0) begin
               // latest load seen during the frame that just ended takes effect
               if (has_load && last_idx >= bnd_prev[m]) begin
                  act_pat[m]  = last_val;
                  act_mask[m] = last_mask;
               end
               bnd_prev[m] = cnt;
            end
         end
      end
   end

   task automatic expected(input int m, output logic [3:0] ed, output logic [7:0] es,
                           output logic ef);
      int s, pos, slot, d, w;
      ed = 4'hF;
      es = 8'hFF;
      ef = 1'b0;
      if (cnt > 0) begin
         s    = cnt - 1;
         pos  = s % period(m);
         slot = PS + dead(m);
         d    = pos / slot;
         w    = pos % slot;
         if (w < PS && out_mask[m][d]) begin
            ed[d] = 1'b0;
            es    = out_pat[m][d*8 +: 8];
         end
         ef = (cnt % period(m) == 0);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] ed;
      logic [7:0] es;
      logic       ef;
      expected(0, ed, es, ef);
      check("digits0", dig0, ed);
      check("segments0", seg0, es);
      check("frame_done0", fd0, ef);
      expected(1, ed, es, ef);
      check("digits1", dig1, ed);
      check("segments1", seg1, es);
      check("frame_done1", fd1, ef);
   end

   // Counts negedges until frame_done of instance m is seen (bounded).
   task automatic wait_fd(input int m, output int n);
      logic f;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         f = (m == 0) ? fd0 : fd1;
      end while (!f && n < 200);
      if (!f) check("frame_done_timeout", f, 1'b1);
   endtask

   task automatic drive_point();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int n, blanks, shown0, shown2;
      bit found;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, blanks, shown0, shown2;
      bit found;
      model_reset();
      #7;
      check("reset_digits0", dig0, 4'hF);
      check("reset_segments0", seg0, 8'hFF);
      check("reset_frame_done0", fd0, 1'b0);
      check("reset_digits1", dig1, 4'hF);
      check("reset_segments1", seg1, 8'hFF);
      check("reset_frame_done1", fd1, 1'b0);

      drive_point();
      rst_n = 1'b1;
      load  = 1'b1;
      din   = 32'h44332211;
      den   = 4'b1111;
      drive_point();
      load = 1'b0;

      wait_fd(0, n);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("seq_d0_digits", dig0, 4'b1110);
         check("seq_d0_segments", seg0, 8'h11);
      end
      @(negedge clk);
      check("seq_dead_digits", dig0, 4'b1111);
      check("seq_dead_segments", seg0, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("seq_d1_digits", dig0, 4'b1101);
         check("seq_d1_segments", seg0, 8'h22);
      end

      wait_fd(0, n);
      wait_fd(0, n);
      check("period_dead1", n, P0);
      wait_fd(1, n);
      wait_fd(1, n);
      check("period_dead0", n, P1);

      drive_point();
      load = 1'b1;
      din  = 32'hD4C3B2A1;
      den  = 4'b0101;
      drive_point();
      load = 1'b0;
      wait_fd(0, n);
      blanks = 0;
      shown0 = 0;
      shown2 = 0;
      for (int i = 0; i < P0; i++) begin
         @(negedge clk);
         if (dig0 == 4'b1111 && seg0 == 8'hFF) blanks++;
         if (dig0 == 4'b1110 && seg0 == 8'hA1) shown0++;
         if (dig0 == 4'b1011 && seg0 == 8'hC3) shown2++;
      end
      check("mask0101_blank_cycles", blanks, 12);
      check("mask0101_digit0_cycles", shown0, 4);
      check("mask0101_digit2_cycles", shown2, 4);

      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         found = (dig0 == 4'b1011);
      end
      check("digit2_slot_reached", found, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_digits0", dig0, 4'hF);
      check("midreset_segments0", seg0, 8'hFF);
      check("midreset_digits1", dig1, 4'hF);
      check("midreset_segments1", seg1, 8'hFF);
      drive_point();
      drive_point();
      rst_n = 1'b1;
      for (int i = 0; i < 45; i++) drive_point();

      for (int i = 0; i < 1500; i++) begin
         drive_point();
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            load  = 1'b0;
            repeat ($urandom_range(1, 3)) drive_point();
            rst_n = 1'b1;
         end else begin
            load = ($urandom_range(0, 9) == 0);
            din  = $urandom;
            den  = 4'($urandom);
         end
      end
      load = 1'b0;
      repeat (45) drive_point();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
